// File: rtl/product_bcd_if.sv
// Handshake and result bundle between the Booth product source and the BCD converter.
// Master drives start/bin; slave returns busy/done and the registered sign + BCD digits.
interface product_bcd_if;
   logic       start;
   logic [7:0] bin;
   logic       busy;
   logic       done;
   logic       sign;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;

   modport master (
      output start,
      output bin,
      input  busy,
      input  done,
      input  sign,
      input  hundreds,
      input  tens,
      input  ones
   );

   modport slave (
      input  start,
      input  bin,
      output busy,
      output done,
      output sign,
      output hundreds,
      output tens,
      output ones
   );
endinterface

// File: rtl/product_bcd.sv
// Signed 8-bit to sign + 3-digit BCD via double dabble, one bit per clock; done 8 edges after start.
// start is only honoured in IDLE (no queueing); results hold until the next conversion completes.
module product_bcd (
   input  logic         clk,
   input  logic         rst,
   product_bcd_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q,    state_d;
   logic [7:0]  mag_q,      mag_d;
   logic [11:0] scratch_q,  scratch_d;
   logic [2:0]  count_q,    count_d;
   logic        sign_r_q,   sign_r_d;
   logic        busy_q,     busy_d;
   logic        done_q,     done_d;
   logic        sign_q,     sign_d;
   logic [3:0]  hundreds_q, hundreds_d;
   logic [3:0]  tens_q,     tens_d;
   logic [3:0]  ones_q,     ones_d;

   logic [11:0] adjusted;
   logic [19:0] shifted;

   function automatic logic [3:0] add3(input logic [3:0] digit);
      return (digit >= 4'd5) ? digit + 4'd3 : digit;
   endfunction

   // Magnitude never exceeds 128, so no digit reaches 10 before its adjust.
   always_comb begin
      adjusted = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
      shifted  = {adjusted, mag_q} << 1;
   end

   always_comb begin
      state_d    = state_q;
      mag_d      = mag_q;
      scratch_d  = scratch_q;
      count_d    = count_q;
      sign_r_d   = sign_r_q;
      sign_d     = sign_q;
      hundreds_d = hundreds_q;
      tens_d     = tens_q;
      ones_d     = ones_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               sign_r_d  = bus.bin[7];
               // 8-bit negate equals the 9-bit negate truncated: -128 maps to 128.
               mag_d     = bus.bin[7] ? (8'd0 - bus.bin) : bus.bin;
               scratch_d = 12'd0;
               count_d   = 3'd0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = shifted[19:8];
            mag_d     = shifted[7:0];
            count_d   = count_q + 3'd1;
            if (count_q == 3'd7) begin
               sign_d     = sign_r_q;
               hundreds_d = shifted[19:16];
               tens_d     = shifted[15:12];
               ones_d     = shifted[11:8];
               state_d    = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mag_q      <= 8'd0;
         scratch_q  <= 12'd0;
         count_q    <= 3'd0;
         sign_r_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sign_q     <= 1'b0;
         hundreds_q <= 4'd0;
         tens_q     <= 4'd0;
         ones_q     <= 4'd0;
      end else begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         scratch_q  <= scratch_d;
         count_q    <= count_d;
         sign_r_q   <= sign_r_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sign_q     <= sign_d;
         hundreds_q <= hundreds_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sign     = sign_q;
   assign bus.hundreds = hundreds_q;
   assign bus.tens     = tens_q;
   assign bus.ones     = ones_q;

endmodule

// File: tb/tb_product_bcd.sv
// Directed bench for product_bcd: latency, busy window, extremes, start hold-off, async reset, Booth products.
module tb_product_bcd;
   logic clk = 1'b0;
   logic rst;

   product_bcd_if bus();

   product_bcd dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [12:0] res;
   assign res = {bus.sign, bus.hundreds, bus.tens, bus.ones};

   // Pulses start for one edge, then observes 20 edges: first done edge, busy samples, done pulses.
   task automatic run_conv(input logic [7:0] v, output int lat, output int bsy, output int dn);
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = v;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.bin   = ~v;
      lat = -1;
      bsy = 0;
      dn  = 0;
      for (int i = 1; i <= 20; i++) begin
         if (bus.busy) bsy++;
         @(posedge clk); #1;
         if (bus.done) begin
            dn++;
            if (lat < 0) lat = i;
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.bin   = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
      chk_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_cnt++;
      chk_cnt++; if (res !== 13'h0000) $display("FAIL reset_result: got %h want 0000", res); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b want 0", bus.busy); else pass_cnt++;
   endtask

   task automatic test_neg18();
      int lat, bsy, dn;
      run_conv(8'hEE, lat, bsy, dn);
      chk_cnt++; if (lat !== 8) $display("FAIL neg18_latency: got %0d want 8", lat); else pass_cnt++;
      chk_cnt++; if (bsy !== 9) $display("FAIL neg18_busy_cycles: got %0d want 9", bsy); else pass_cnt++;
      chk_cnt++; if (dn !== 1) $display("FAIL neg18_done_pulses: got %0d want 1", dn); else pass_cnt++;
      chk_cnt++; if (res !== 13'h1018) $display("FAIL neg18_result: got %h want 1018", res); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat, bsy, dn;
      run_conv(8'h08, lat, bsy, dn);
      chk_cnt++; if (res !== 13'h0008) $display("FAIL pos8_result: got %h want 0008", res); else pass_cnt++;
      chk_cnt++; if (lat !== 8) $display("FAIL pos8_latency: got %0d want 8", lat); else pass_cnt++;
      run_conv(8'h00, lat, bsy, dn);
      chk_cnt++; if (res !== 13'h0000) $display("FAIL zero_result: got %h want 0000", res); else pass_cnt++;
      chk_cnt++; if (dn !== 1) $display("FAIL zero_done_pulses: got %0d want 1", dn); else pass_cnt++;
   endtask

   task automatic test_extremes();
      logic [7:0]  vin [3] = '{8'h80, 8'h7F, 8'hFF};
      logic [12:0] vexp[3] = '{13'h1128, 13'h0127, 13'h1001};
      int lat, bsy, dn;
      for (int k = 0; k < 3; k++) begin
         run_conv(vin[k], lat, bsy, dn);
         chk_cnt++;
         if (res !== vexp[k]) $display("FAIL extreme_%h_result: got %h want %h", vin[k], res, vexp[k]);
         else pass_cnt++;
         chk_cnt++;
         if (bsy !== 9) $display("FAIL extreme_%h_busy_cycles: got %0d want 9", vin[k], bsy);
         else pass_cnt++;
      end
   endtask

   task automatic test_start_held();
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = 8'hEE;
      @(posedge clk); #1;
      for (int i = 1; i <= 18; i++) begin
         @(posedge clk); #1;
         if (i == 3) bus.bin = 8'h7F;
         if (i == 4) begin
            chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL held_busy_mid: got %b want 1", bus.busy); else pass_cnt++;
         end
         if (i == 8) begin
            chk_cnt++; if (bus.done !== 1'b1) $display("FAIL held_first_done: got %b want 1", bus.done); else pass_cnt++;
            chk_cnt++; if (res !== 13'h1018) $display("FAIL held_first_result: got %h want 1018", res); else pass_cnt++;
         end
         if (i == 9) begin
            chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL held_idle_gap: busy got %b want 0", bus.busy); else pass_cnt++;
            chk_cnt++; if (bus.done !== 1'b0) $display("FAIL held_done_fall: got %b want 0", bus.done); else pass_cnt++;
         end
         if (i == 10) begin
            chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL held_recapture: busy got %b want 1", bus.busy); else pass_cnt++;
         end
         if (i == 17) begin
            chk_cnt++; if (res !== 13'h1018) $display("FAIL held_result_hold: got %h want 1018", res); else pass_cnt++;
         end
         if (i == 18) begin
            chk_cnt++; if (bus.done !== 1'b1) $display("FAIL held_second_done: got %b want 1", bus.done); else pass_cnt++;
            chk_cnt++; if (res !== 13'h0127) $display("FAIL held_second_result: got %h want 0127", res); else pass_cnt++;
         end
      end
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_abort();
      int lat, bsy, dn;
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = 8'hE8;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else pass_cnt++;
      chk_cnt++; if (res !== 13'h0000) $display("FAIL abort_result_clear: got %h want 0000", res); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) dn++;
      end
      chk_cnt++; if (dn !== 0) $display("FAIL abort_no_done: activity cycles got %0d want 0", dn); else pass_cnt++;
      run_conv(8'h08, lat, bsy, dn);
      chk_cnt++; if (res !== 13'h0008) $display("FAIL after_abort_result: got %h want 0008", res); else pass_cnt++;
      chk_cnt++; if (lat !== 8) $display("FAIL after_abort_latency: got %0d want 8", lat); else pass_cnt++;
   endtask

   task automatic test_booth_chain();
      int          op_a[4] = '{6, -4, -6, 4};
      int          op_b[4] = '{-3, -2, 3, 2};
      logic [12:0] vexp[4] = '{13'h1018, 13'h0008, 13'h1018, 13'h0008};
      logic [7:0]  c;
      int lat, bsy, dn;
      for (int k = 0; k < 4; k++) begin
         c = 8'(op_a[k] * op_b[k]);
         run_conv(c, lat, bsy, dn);
         chk_cnt++;
         if (res !== vexp[k]) $display("FAIL booth_%0d_result: got %h want %h", k, res, vexp[k]);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_neg18();
      test_back_to_back();
      test_extremes();
      test_start_held();
      test_reset_abort();
      test_booth_chain();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
